// File: rtl/line_draw_pkg.sv
// Shared types and defaults for the streaming Bresenham line drawer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package line_draw_pkg;

  localparam int DEF_COORD_W = 11;
  // The accumulator swings between -major and +major, so one bit for the
  // sign and one of headroom above the coordinate width are enough.
  localparam int DEF_ERR_W   = DEF_COORD_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef logic signed [DEF_ERR_W-1:0] err_t;

endpackage

// File: rtl/line_drawer_setup.sv
// Derives Bresenham parameters (deltas, step directions, major axis, seed error) from two endpoints.
// Latency: purely combinational.
// Backpressure: none; outputs follow the inputs.
// Ports: i_x0/i_y0/i_x1/i_y1 endpoints; o_sx_neg/o_sy_neg step direction is -1;
//        o_steep y is the major axis; o_major/o_minor axis lengths; o_err initial error.
module line_drawer_setup
  import line_draw_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int ERR_W   = COORD_W + 2
) (
  input  logic [COORD_W-1:0]      i_x0,
  input  logic [COORD_W-1:0]      i_y0,
  input  logic [COORD_W-1:0]      i_x1,
  input  logic [COORD_W-1:0]      i_y1,
  output logic                    o_sx_neg,
  output logic                    o_sy_neg,
  output logic                    o_steep,
  output logic [COORD_W-1:0]      o_major,
  output logic [COORD_W-1:0]      o_minor,
  output logic signed [ERR_W-1:0] o_err
);

  logic [COORD_W-1:0] w_adx;
  logic [COORD_W-1:0] w_ady;

  // Unsigned absolute differences: subtract the smaller from the larger so
  // the full 0..2^COORD_W-1 range is handled without a sign bit.
  assign w_adx    = (i_x1 >= i_x0) ? (i_x1 - i_x0) : (i_x0 - i_x1);
  assign w_ady    = (i_y1 >= i_y0) ? (i_y1 - i_y0) : (i_y0 - i_y1);
  assign o_sx_neg = (i_x1 < i_x0);
  assign o_sy_neg = (i_y1 < i_y0);

  // Strict compare: a 45-degree line stays x-major.
  assign o_steep  = (w_ady > w_adx);
  assign o_major  = o_steep ? w_ady : w_adx;
  assign o_minor  = o_steep ? w_adx : w_ady;

  // major>>1 is non-negative, so zero-extension equals sign-extension here.
  assign o_err    = $signed({{(ERR_W-COORD_W){1'b0}}, (o_major >> 1)});

endmodule

// File: rtl/line_drawer_stream.sv
// Walks Bresenham pixels from (x0,y0) to (x1,y1) in any octant and streams them out with a last flag.
// Latency: start sampled at edge t -> busy after t, first pixel valid after t+1; one pixel per cycle at full rate.
// Backpressure: px_ready low freezes px_x/px_y/px_last and the walk; done pulses the cycle after the last handshake.
// Ports: clk/reset (async, active-high); start/abort control; x0..y1 endpoints captured on start;
//        busy status; px_valid/px_ready/px_x/px_y/px_last pixel stream; done completion pulse.
module line_drawer_stream
  import line_draw_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int ERR_W   = COORD_W + 2   // must be >= COORD_W+2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic               px_last,
  output logic               done
);

  localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  state_t                    r_state;
  logic [COORD_W-1:0]        r_x0, r_y0, r_x1, r_y1;
  logic                      r_sx_neg, r_sy_neg, r_steep;
  logic [COORD_W-1:0]        r_major, r_minor;
  logic signed [ERR_W-1:0]   r_err;
  logic [COORD_W-1:0]        r_n;
  logic [COORD_W-1:0]        r_px_x, r_px_y;
  logic                      r_valid, r_last, r_busy, r_done;

  logic                      w_set_sx_neg, w_set_sy_neg, w_set_steep;
  logic [COORD_W-1:0]        w_set_major, w_set_minor;
  logic signed [ERR_W-1:0]   w_set_err;

  logic                      w_hs;
  logic signed [ERR_W-1:0]   w_major_s, w_minor_s, w_err_dec;
  logic                      w_err_neg;
  logic [COORD_W-1:0]        w_x_next, w_y_next;

  line_drawer_setup #(
    .COORD_W (COORD_W),
    .ERR_W   (ERR_W)
  ) u_setup (
    .i_x0     (r_x0),
    .i_y0     (r_y0),
    .i_x1     (r_x1),
    .i_y1     (r_y1),
    .o_sx_neg (w_set_sx_neg),
    .o_sy_neg (w_set_sy_neg),
    .o_steep  (w_set_steep),
    .o_major  (w_set_major),
    .o_minor  (w_set_minor),
    .o_err    (w_set_err)
  );

  assign w_hs      = r_valid & px_ready;
  assign w_major_s = $signed({{(ERR_W-COORD_W){1'b0}}, r_major});
  assign w_minor_s = $signed({{(ERR_W-COORD_W){1'b0}}, r_minor});
  assign w_err_dec = r_err - w_minor_s;
  assign w_err_neg = w_err_dec[ERR_W-1];
  assign w_x_next  = r_sx_neg ? (r_px_x - ONE) : (r_px_x + ONE);
  assign w_y_next  = r_sy_neg ? (r_px_y - ONE) : (r_px_y + ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_steep  <= 1'b0;
      r_major  <= '0;
      r_minor  <= '0;
      r_err    <= '0;
      r_n      <= '0;
      r_px_x   <= '0;
      r_px_y   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // abort wins over a coincident start; otherwise latch the request.
          if (start && !abort) begin
            r_x0    <= x0;
            r_y0    <= y0;
            r_x1    <= x1;
            r_y1    <= y1;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end

        SETUP: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_sx_neg <= w_set_sx_neg;
            r_sy_neg <= w_set_sy_neg;
            r_steep  <= w_set_steep;
            r_major  <= w_set_major;
            r_minor  <= w_set_minor;
            r_err    <= w_set_err;
            r_n      <= w_set_major;
            r_px_x   <= r_x0;
            r_px_y   <= r_y0;
            r_valid  <= 1'b1;
            r_last   <= (w_set_major == '0);
            r_state  <= DRAW;
          end
        end

        DRAW: begin
          if (abort) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_hs) begin
            if (r_n == '0) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              // Major axis always steps; minor axis steps when the error goes negative.
              if (r_steep) begin
                r_px_y <= w_y_next;
                if (w_err_neg) r_px_x <= w_x_next;
              end else begin
                r_px_x <= w_x_next;
                if (w_err_neg) r_px_y <= w_y_next;
              end
              r_err  <= w_err_neg ? (w_err_dec + w_major_s) : w_err_dec;
              r_n    <= r_n - ONE;
              r_last <= (r_n == ONE);
            end
          end
        end

        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign px_valid = r_valid;
  assign px_x     = r_px_x;
  assign px_y     = r_px_y;
  assign px_last  = r_last;
  assign done     = r_done;

endmodule

// File: tb/tb_line_drawer_stream.sv
module tb_line_drawer_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, px_ready;
  logic [10:0] x0, y0, x1, y1, px_x, px_y;
  logic        busy, px_valid, px_last, done;

  line_drawer_stream #(.COORD_W(11), .ERR_W(13)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_last(px_last), .done(done)
  );

  logic        b_start, b_abort, b_ready, b_busy, b_valid, b_last, b_done;
  logic [15:0] bx0, by0, bx1, by1, b_px_x, b_px_y;

  line_drawer_stream #(.COORD_W(16), .ERR_W(18)) dut_w (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
    .x0(bx0), .y0(by0), .x1(bx1), .y1(by1),
    .busy(b_busy), .px_valid(b_valid), .px_ready(b_ready),
    .px_x(b_px_x), .px_y(b_px_y), .px_last(b_last), .done(b_done)
  );

  int n_err = 0;
  int n_chk = 0;

  int q_x[$], q_y[$], q_l[$];
  int ex_x[$], ex_y[$];
  int ref_x[$], ref_y[$];
  int first_valid_cyc, done_cyc, done_cnt, last_hs_cyc, hold_err, hs_cnt, busy_c1, valid_at_done;
  int opt_rand, opt_poke_cyc, opt_abort_hs, opt_reset_hs;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare the captured pixel stream against ex_x/ex_y; px_last only on the final pixel.
  task automatic chk_seq(input string tag);
    chk({tag, " count"}, q_x.size(), ex_x.size());
    if (q_x.size() == ex_x.size()) begin
      for (int i = 0; i < ex_x.size(); i++) begin
        chk($sformatf("%s x[%0d]", tag, i), q_x[i], ex_x[i]);
        chk($sformatf("%s y[%0d]", tag, i), q_y[i], ex_y[i]);
        chk($sformatf("%s last[%0d]", tag, i), q_l[i], (i == ex_x.size() - 1) ? 1 : 0);
      end
    end
  endtask

  // Issue one line and collect handshaken pixels. Inputs change and outputs
  // are sampled on the falling edge; cycle 0 is the falling edge raising start.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1, input int max_cyc);
    int  prev_x, prev_y, prev_l, abort_cyc;
    bit  stalled;
    q_x.delete(); q_y.delete(); q_l.delete();
    first_valid_cyc = -1; done_cyc = -1; done_cnt = 0; last_hs_cyc = -1;
    hold_err = 0; hs_cnt = 0; busy_c1 = -1; valid_at_done = -1;
    abort_cyc = -1; stalled = 1'b0; prev_x = 0; prev_y = 0; prev_l = 0;
    @(negedge clk);
    x0 = 11'(ax0); y0 = 11'(ay0); x1 = 11'(ax1); y1 = 11'(ay1);
    start = 1'b1; abort = 1'b0; px_ready = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (cyc == opt_poke_cyc) begin
        start = 1'b1; x0 = 11'd100; y0 = 11'd100; x1 = 11'd0; y1 = 11'd0;
      end
      if (cyc == 1) busy_c1 = int'(busy);
      if (stalled && (int'(px_x) != prev_x || int'(px_y) != prev_y || int'(px_last) != prev_l))
        hold_err++;
      if (px_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; valid_at_done = int'(px_valid); end
      end
      if (done || (abort_cyc >= 0 && cyc >= abort_cyc + 2)) break;
      if (opt_reset_hs > 0 && hs_cnt == opt_reset_hs) begin
        #2 reset = 1'b1;
        #1;
        return;
      end
      if (opt_abort_hs > 0 && hs_cnt == opt_abort_hs && abort_cyc < 0) begin
        abort = 1'b1; px_ready = 1'b0; abort_cyc = cyc;
      end else if (abort_cyc >= 0) begin
        px_ready = 1'b0;
      end else begin
        px_ready = opt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      stalled = px_valid && !px_ready;
      prev_x = int'(px_x); prev_y = int'(px_y); prev_l = int'(px_last);
      if (px_valid && px_ready) begin
        q_x.push_back(int'(px_x)); q_y.push_back(int'(px_y)); q_l.push_back(int'(px_last));
        hs_cnt++;
        last_hs_cyc = cyc;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int cnt, bad, lx, ly, bdone;
    logic [15:0] w_exp_y;

    reset = 1'b1; start = 1'b0; abort = 1'b0; px_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
    bx0 = '0; by0 = '0; bx1 = '0; by1 = '0;
    opt_rand = 0; opt_poke_cyc = -1; opt_abort_hs = 0; opt_reset_hs = 0;

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst px_valid", px_valid, 0);
    chk("rst px_last", px_last, 0);
    chk("rst done", done, 0);
    chk("rst px_x", px_x, 0);
    chk("rst px_y", px_y, 0);
    reset = 1'b0;

    // Shallow line, x-major, full rate.
    run_line(0, 0, 10, 5, 100);
    ex_x = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    ex_y = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    chk("shallow busy after start", busy_c1, 1);
    chk("shallow first valid cycle", first_valid_cyc, 2);
    chk_seq("shallow");
    chk("shallow done count", done_cnt, 1);
    chk("shallow done after last", done_cyc, last_hs_cyc + 1);
    chk("shallow valid low at done", valid_at_done, 0);
    @(negedge clk);
    chk("shallow busy idle", busy, 0);
    chk("shallow done pulse width", done, 0);

    // Reversed steep line.
    run_line(5, 10, 0, 0, 100);
    ex_x = '{5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0};
    ex_y = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    chk_seq("steep");
    chk("steep done count", done_cnt, 1);

    // 45 degrees.
    run_line(0, 0, 10, 10, 100);
    ex_x.delete(); ex_y.delete();
    for (int i = 0; i <= 10; i++) begin ex_x.push_back(i); ex_y.push_back(i); end
    chk_seq("diag");

    // Backpressure: reference run at full rate, then a stalled run.
    run_line(0, 200, 50, 190, 200);
    ref_x = q_x; ref_y = q_y;
    chk("bp ref count", q_x.size(), 51);
    if (q_x.size() == 51) begin
      chk("bp ref x[3]", q_x[3], 3);
      chk("bp ref y[2]", q_y[2], 200);
      chk("bp ref y[3]", q_y[3], 199);
      chk("bp ref end x", q_x[50], 50);
      chk("bp ref end y", q_y[50], 190);
    end
    opt_rand = 1;
    run_line(0, 200, 50, 190, 600);
    opt_rand = 0;
    ex_x = ref_x; ex_y = ref_y;
    chk_seq("bp stalled");
    chk("bp hold while stalled", hold_err, 0);
    chk("bp done count", done_cnt, 1);
    chk("bp done after last", done_cyc, last_hs_cyc + 1);

    // Degenerate single point.
    run_line(7, 7, 7, 7, 50);
    ex_x = '{7}; ex_y = '{7};
    chk_seq("point");
    chk("point done count", done_cnt, 1);
    chk("point done after last", done_cyc, last_hs_cyc + 1);

    // Horizontal, right to left.
    run_line(10, 0, 0, 0, 100);
    ex_x = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    ex_y = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("horiz");

    // start while busy is dropped, not queued.
    opt_poke_cyc = 4;
    run_line(0, 0, 10, 5, 100);
    opt_poke_cyc = -1;
    ex_x = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    ex_y = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    chk_seq("poke");
    chk("poke done count", done_cnt, 1);
    repeat (3) @(negedge clk);
    chk("poke not queued busy", busy, 0);
    chk("poke not queued valid", px_valid, 0);

    // abort after 3 handshakes, then a fresh line.
    opt_abort_hs = 3;
    run_line(0, 0, 10, 5, 50);
    opt_abort_hs = 0;
    chk("abort handshakes", hs_cnt, 3);
    chk("abort no done", done_cnt, 0);
    chk("abort valid low", px_valid, 0);
    chk("abort busy low", busy, 0);
    run_line(10, 0, 0, 0, 100);
    ex_x = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    ex_y = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("after abort");
    chk("after abort done count", done_cnt, 1);

    // Asynchronous reset in the middle of a line.
    opt_reset_hs = 4;
    run_line(0, 0, 10, 5, 100);
    opt_reset_hs = 0;
    chk("areset handshakes before", hs_cnt, 4);
    chk("areset busy", busy, 0);
    chk("areset px_valid", px_valid, 0);
    chk("areset px_x", px_x, 0);
    chk("areset px_y", px_y, 0);
    chk("areset px_last", px_last, 0);
    chk("areset done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("areset no done later", done, 0);
    chk("areset stays idle", busy, 0);

    // 16-bit instance spanning the full x range.
    @(negedge clk);
    bx0 = 16'd0; by0 = 16'd0; bx1 = 16'hFFFF; by1 = 16'd1;
    b_start = 1'b1; b_ready = 1'b1;
    cnt = 0; bad = 0; lx = -1; ly = -1; bdone = 0;
    for (int cyc = 1; cyc <= 70000; cyc++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_valid) begin
        w_exp_y = (cnt >= 32768) ? 16'd1 : 16'd0;
        if (b_px_x != 16'(cnt) || b_px_y != w_exp_y) bad++;
        if (b_last != (cnt == 65535)) bad++;
        if (b_last) begin lx = int'(b_px_x); ly = int'(b_px_y); end
        cnt++;
      end
      if (b_done) begin bdone++; break; end
    end
    chk("wide pixel count", cnt, 65536);
    chk("wide pixel errors", bad, 0);
    chk("wide last x", lx, 65535);
    chk("wide last y", ly, 1);
    chk("wide done", bdone, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
